// File: rtl/capp_pkg.sv
// Shared types and line-encoding helpers for the CAPP host-side controller.
package capp_pkg;

    localparam int unsigned DEF_WORDS         = 100;
    localparam int unsigned DEF_WIDTH         = 32;
    localparam int unsigned DEF_IDXW          = 7;
    localparam int unsigned DEF_SETTLE_CYCLES = 2;

    typedef enum logic [1:0] {
        OpSearch    = 2'd0,
        OpReadNext  = 2'd1,
        OpWrite     = 2'd2,
        OpSelectAll = 2'd3
    } capp_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StCapture,
        StWpulse,
        StResp
    } capp_state_e;

    // {flag stored 1, flag stored 0} for one bit column
    function automatic logic [1:0] mismatch_pair(input logic key, input logic mask);
        return {mask & ~key, mask & key};
    endfunction

    // {set, clear} for one bit column
    function automatic logic [1:0] write_pair(input logic key, input logic mask);
        return {mask & key, mask & ~key};
    endfunction

endpackage

// File: rtl/capp_if.sv
// Host command/response channel of the CAPP controller.
interface capp_if #(
    parameter int unsigned WIDTH = capp_pkg::DEF_WIDTH,
    parameter int unsigned IDXW  = capp_pkg::DEF_IDXW
) ();
    import capp_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    capp_op_e         cmd_op;
    logic [WIDTH-1:0] cmd_key;
    logic [WIDTH-1:0] cmd_mask;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_hit;
    logic [IDXW:0]    rsp_count;
    logic [IDXW-1:0]  rsp_index;
    logic [WIDTH-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_key, cmd_mask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_hit, rsp_count, rsp_index, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_key, cmd_mask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_hit, rsp_count, rsp_index, rsp_data
    );

endinterface

// File: rtl/capp_first_responder.sv
// Lowest-index-first resolution of the responder register (purely combinational).
module capp_first_responder #(
    parameter int unsigned WORDS = capp_pkg::DEF_WORDS,
    parameter int unsigned IDXW  = capp_pkg::DEF_IDXW
) (
    input  logic [WORDS-1:0] vec,
    output logic [WORDS-1:0] onehot,
    output logic [IDXW-1:0]  index,
    output logic             any
);

    // Two's-complement trick isolates the lowest set bit
    assign onehot = vec & (~vec + WORDS'(1));
    assign any    = |vec;

    always_comb begin
        index = '0;
        for (int i = int'(WORDS) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                index = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/capp_controller.sv
// Host-side sequencer for the CAPP cell array: drives array lines, samples results,
// keeps the responder register and returns results over a valid/ready port.
module capp_controller
    import capp_pkg::*;
#(
    parameter int unsigned WORDS         = DEF_WORDS,
    parameter int unsigned WIDTH         = DEF_WIDTH,
    parameter int unsigned IDXW          = DEF_IDXW,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    capp_if.slave              bus,
    output logic [2*WIDTH-1:0] mismatch_lines,
    output logic [2*WIDTH-1:0] write_lines,
    output logic [WORDS-1:0]   select_lines,
    input  logic [WORDS-1:0]   match_lines,
    input  logic [WIDTH-1:0]   read_lines
);

    localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);

    capp_state_e      state_q, state_d;
    capp_op_e         op_q, op_d;
    logic [WIDTH-1:0] key_q, key_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WORDS-1:0] resp_q, resp_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             rd_hit_q, rd_hit_d;
    logic [IDXW-1:0]  rd_index_q, rd_index_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    logic [WORDS-1:0] fr_onehot;
    logic [IDXW-1:0]  fr_index;
    logic             fr_any;
    logic [IDXW:0]    pop;

    capp_first_responder #(
        .WORDS (WORDS),
        .IDXW  (IDXW)
    ) u_first (
        .vec    (resp_q),
        .onehot (fr_onehot),
        .index  (fr_index),
        .any    (fr_any)
    );

    always_comb begin
        pop = '0;
        for (int i = 0; i < int'(WORDS); i++) begin
            pop = pop + {{IDXW{1'b0}}, resp_q[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            op_q       <= OpSearch;
            key_q      <= '0;
            mask_q     <= '0;
            resp_q     <= '0;
            cnt_q      <= '0;
            rd_hit_q   <= 1'b0;
            rd_index_q <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            key_q      <= key_d;
            mask_q     <= mask_d;
            resp_q     <= resp_d;
            cnt_q      <= cnt_d;
            rd_hit_q   <= rd_hit_d;
            rd_index_q <= rd_index_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        key_d      = key_q;
        mask_d     = mask_q;
        resp_d     = resp_q;
        cnt_d      = cnt_q;
        rd_hit_d   = rd_hit_q;
        rd_index_d = rd_index_q;
        rd_data_d  = rd_data_q;

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    op_d       = bus.cmd_op;
                    key_d      = bus.cmd_key;
                    mask_d     = bus.cmd_mask;
                    cnt_d      = '0;
                    rd_hit_d   = 1'b0;
                    rd_index_d = '0;
                    rd_data_d  = '0;
                    unique case (bus.cmd_op)
                        OpSearch:    state_d = StSettle;
                        OpReadNext:  state_d = fr_any ? StSettle : StResp;
                        OpWrite:     state_d = StWpulse;
                        OpSelectAll: begin
                            resp_d  = '1;
                            state_d = StResp;
                        end
                        default:     state_d = StIdle;
                    endcase
                end
            end
            StSettle: begin
                if (cnt_q == CntW'(SETTLE_CYCLES - 1)) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StCapture: begin
                if (op_q == OpSearch) begin
                    resp_d = ~match_lines;
                end else begin
                    rd_hit_d   = 1'b1;
                    rd_index_d = fr_index;
                    rd_data_d  = read_lines;
                    resp_d     = resp_q & ~fr_onehot;
                end
                state_d = StResp;
            end
            StWpulse: state_d = StResp;
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Array lines are pure functions of state so a reset drops them immediately
    always_comb begin
        mismatch_lines = '0;
        write_lines    = '0;
        select_lines   = '0;
        if (state_q == StSettle || state_q == StCapture) begin
            if (op_q == OpSearch) begin
                for (int j = 0; j < int'(WIDTH); j++) begin
                    mismatch_lines[2*j +: 2] = mismatch_pair(key_q[j], mask_q[j]);
                end
            end else begin
                select_lines = fr_onehot;
            end
        end else if (state_q == StWpulse) begin
            select_lines = resp_q;
            for (int j = 0; j < int'(WIDTH); j++) begin
                write_lines[2*j +: 2] = write_pair(key_q[j], mask_q[j]);
            end
        end
    end

    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_hit   = bus.rsp_valid & ((op_q == OpReadNext) ? rd_hit_q : fr_any);
    assign bus.rsp_count = bus.rsp_valid ? pop : '0;
    assign bus.rsp_index = bus.rsp_valid ? rd_index_q : '0;
    assign bus.rsp_data  = bus.rsp_valid ? rd_data_q : '0;

endmodule

// File: tb/tb_capp_controller.sv
// Scoreboard bench for capp_controller against a behavioural CAPP array model.
module tb_capp_controller;
    import capp_pkg::*;

    localparam int unsigned WORDS  = 100;
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned IDXW   = 7;
    localparam int unsigned SETTLE = 2;

    typedef struct packed {
        logic             hit;
        logic [IDXW:0]    count;
        logic [IDXW-1:0]  index;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic model_load = 1'b1;

    logic [2*WIDTH-1:0] mismatch_lines, write_lines;
    logic [WORDS-1:0]   select_lines, match_lines;
    logic [WIDTH-1:0]   read_lines;
    logic [WIDTH-1:0]   mem [WORDS];

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    logic [2*WIDTH-1:0] snap_mm, snap_wr;
    logic [WORDS-1:0]   snap_sel;

    capp_if #(.WIDTH(WIDTH), .IDXW(IDXW)) bus ();

    capp_controller #(
        .WORDS         (WORDS),
        .WIDTH         (WIDTH),
        .IDXW          (IDXW),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .mismatch_lines (mismatch_lines),
        .write_lines    (write_lines),
        .select_lines   (select_lines),
        .match_lines    (match_lines),
        .read_lines     (read_lines)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] init_word(input int i);
        case (i)
            0:       return 32'd456;
            1:       return 32'd457;
            2:       return 32'd1000;
            3:       return 32'd1000;
            4:       return 32'd457;
            default: return 32'h1000_0001 + (WIDTH'(i) << 4);
        endcase
    endfunction

    // Array model: a word mismatches if any flagged column disagrees with its stored bit
    always_comb begin
        match_lines = '0;
        read_lines  = '0;
        for (int i = 0; i < int'(WORDS); i++) begin
            for (int j = 0; j < int'(WIDTH); j++) begin
                if ((mismatch_lines[2*j+1] && mem[i][j]) || (mismatch_lines[2*j] && !mem[i][j]))
                    match_lines[i] = 1'b1;
            end
            if (select_lines[i]) read_lines = read_lines | mem[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < int'(WORDS); i++) begin
            if (model_load) begin
                mem[i] <= init_word(i);
            end else if (select_lines[i] && |write_lines) begin
                for (int j = 0; j < int'(WIDTH); j++) begin
                    if (write_lines[2*j+1]) mem[i][j] <= 1'b1;
                    else if (write_lines[2*j]) mem[i][j] <= 1'b0;
                end
            end
        end
    end

    function automatic logic [2*WIDTH-1:0] enc_mm(input logic [WIDTH-1:0] k, input logic [WIDTH-1:0] m);
        logic [2*WIDTH-1:0] r = '0;
        for (int j = 0; j < int'(WIDTH); j++) begin
            r[2*j+1] = m[j] & ~k[j];
            r[2*j]   = m[j] & k[j];
        end
        return r;
    endfunction

    function automatic logic [2*WIDTH-1:0] enc_wr(input logic [WIDTH-1:0] k, input logic [WIDTH-1:0] m);
        logic [2*WIDTH-1:0] r = '0;
        for (int j = 0; j < int'(WIDTH); j++) begin
            r[2*j+1] = m[j] & k[j];
            r[2*j]   = m[j] & ~k[j];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every response handshake
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.rsp_valid) begin
            chk("resp_lines_idle", 128'(|select_lines | |mismatch_lines | |write_lines), 128'd0);
            if (bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got response count=%0d, expected none",
                             bus.rsp_count);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_hit", 128'(bus.rsp_hit), 128'(e.hit));
                    chk("rsp_count", 128'(bus.rsp_count), 128'(e.count));
                    chk("rsp_index", 128'(bus.rsp_index), 128'(e.index));
                    chk("rsp_data", 128'(bus.rsp_data), 128'(e.data));
                end
            end
        end
    end

    task automatic issue(input capp_op_e op, input logic [WIDTH-1:0] key,
                         input logic [WIDTH-1:0] mask);
        int n = 0;
        while (!bus.cmd_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.cmd_ready) chk("cmd_ready_timeout", 128'(bus.cmd_ready), 128'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_key   = key;
        bus.cmd_mask  = mask;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    // Counts edges from accept to rsp_valid; snapshots array lines in the first cycle
    task automatic wait_rsp(input int exp_lat, input bit complete);
        int lat = 0;
        @(negedge clk);
        snap_mm  = mismatch_lines;
        snap_wr  = write_lines;
        snap_sel = select_lines;
        while (!bus.rsp_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("rsp_latency", 128'(lat), 128'(exp_lat));
        if (complete && bus.rsp_valid) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_cmd(input capp_op_e op, input logic [WIDTH-1:0] key,
                          input logic [WIDTH-1:0] mask, input logic hit,
                          input logic [IDXW:0] count, input logic [IDXW-1:0] index,
                          input logic [WIDTH-1:0] data, input int lat);
        exp_q.push_back('{hit: hit, count: count, index: index, data: data});
        issue(op, key, mask);
        wait_rsp(lat, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OpSearch;
        bus.cmd_key   = '0;
        bus.cmd_mask  = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_cmd_ready", 128'(bus.cmd_ready), 128'd1);
        chk("reset_rsp_valid", 128'(bus.rsp_valid), 128'd0);
        chk("reset_rsp_count", 128'(bus.rsp_count), 128'd0);
        chk("reset_lines", 128'(|select_lines | |mismatch_lines | |write_lines), 128'd0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        model_load = 1'b0;

        do_cmd(OpSearch, 32'd457, 32'hFFFF_FFFF, 1'b1, 8'd2, 7'd0, 32'd0, SETTLE + 1);
        chk("search_mismatch_lines", 128'(snap_mm), 128'(enc_mm(32'd457, 32'hFFFF_FFFF)));
        do_cmd(OpReadNext, 32'd0, 32'd0, 1'b1, 8'd1, 7'd1, 32'd457, SETTLE + 1);
        chk("readnext_select", 128'(snap_sel), 128'h2);
        do_cmd(OpReadNext, 32'd0, 32'd0, 1'b1, 8'd0, 7'd4, 32'd457, SETTLE + 1);
        do_cmd(OpReadNext, 32'd0, 32'd0, 1'b0, 8'd0, 7'd0, 32'd0, 0);

        do_cmd(OpSearch, 32'd1000, 32'h0000_000F, 1'b1, 8'd3, 7'd0, 32'd0, SETTLE + 1);
        do_cmd(OpSearch, 32'd1000, 32'hFFFF_FFFF, 1'b1, 8'd2, 7'd0, 32'd0, SETTLE + 1);
        do_cmd(OpWrite, 32'd7, 32'hFFFF_FFFF, 1'b1, 8'd2, 7'd0, 32'd0, 1);
        chk("write_select", 128'(snap_sel), 128'hC);
        chk("write_lines", 128'(snap_wr), 128'(enc_wr(32'd7, 32'hFFFF_FFFF)));
        do_cmd(OpSearch, 32'd7, 32'hFFFF_FFFF, 1'b1, 8'd2, 7'd0, 32'd0, SETTLE + 1);
        do_cmd(OpReadNext, 32'd0, 32'd0, 1'b1, 8'd1, 7'd2, 32'd7, SETTLE + 1);

        do_cmd(OpSelectAll, 32'd0, 32'd0, 1'b1, 8'd100, 7'd0, 32'd0, 0);
        do_cmd(OpSearch, 32'hDEAD_BEEF, 32'd0, 1'b1, 8'd100, 7'd0, 32'd0, SETTLE + 1);
        chk("mask0_mismatch_lines", 128'(snap_mm), 128'd0);

        // Host stalls the response; a competing command must not be taken
        bus.rsp_ready = 1'b0;
        exp_q.push_back('{hit: 1'b1, count: 8'd2, index: 7'd0, data: 32'd0});
        issue(OpSearch, 32'd457, 32'hFFFF_FFFF);
        wait_rsp(SETTLE + 1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = OpSelectAll;
            @(negedge clk);
            chk("stall_rsp_valid", 128'(bus.rsp_valid), 128'd1);
            chk("stall_rsp_count", 128'(bus.rsp_count), 128'd2);
            chk("stall_rsp_hit", 128'(bus.rsp_hit), 128'd1);
            chk("stall_cmd_ready", 128'(bus.cmd_ready), 128'd0);
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_stall_cmd_ready", 128'(bus.cmd_ready), 128'd1);

        // Reset in the middle of a READ_NEXT settle window
        issue(OpReadNext, 32'd0, 32'd0);
        @(negedge clk);
        chk("abort_select_before", 128'(select_lines), 128'h2);
        rst = 1'b1;
        #1;
        chk("abort_cmd_ready", 128'(bus.cmd_ready), 128'd1);
        chk("abort_rsp_valid", 128'(bus.rsp_valid), 128'd0);
        chk("abort_select_after", 128'(select_lines), 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        do_cmd(OpReadNext, 32'd0, 32'd0, 1'b0, 8'd0, 7'd0, 32'd0, 0);

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
